// File: rtl/bnn_net16_pkg.sv
// Shared constants for the 16x16 binary classifier: weights, segment codes, digit encoder.
// Weights are fixed tables here so the XNOR-popcount datapath folds to constants at synthesis.
package bnn_net16_pkg;

   localparam int IMG_W = 16;
   localparam int N_HID = 16;
   localparam int N_CLS = 10;

   typedef logic [IMG_W-1:0][IMG_W-1:0] img_t;

   localparam logic [N_HID-1:0][IMG_W-1:0] W1 = {N_HID{16'hFFFF}};

   // Class k weight is 16'hFFFF >> k; listed from class 9 down to class 0.
   localparam logic [N_CLS-1:0][N_HID-1:0] W2 = {
      16'h007F, 16'h00FF, 16'h01FF, 16'h03FF, 16'h07FF,
      16'h0FFF, 16'h1FFF, 16'h3FFF, 16'h7FFF, 16'hFFFF
   };

   localparam logic [9:0][6:0] SEG_LUT = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [6:0] SEG_DASH = 7'h40;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      s = 7'h00;
      for (int i = 0; i < 10; i++) begin
         if (d == 4'(i)) s = SEG_LUT[i];
      end
      return s;
   endfunction

endpackage

// File: rtl/bnn_xnor_pop.sv
// One binary neuron: count of bit positions where input and weight agree (0..16).
// Purely combinational; no latency, no flow control.
module bnn_xnor_pop (
   input  logic [15:0] i_a,
   input  logic [15:0] i_w,
   output logic [4:0]  o_cnt
);

   logic [15:0] w_x;
   logic [4:0]  w_cnt;

   assign w_x = ~(i_a ^ i_w);

   always_comb begin
      w_cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         w_cnt = w_cnt + {4'd0, w_x[i]};
      end
   end

   assign o_cnt = w_cnt;

endmodule

// File: rtl/bnn_net16_top.sv
// Two-layer XNOR-popcount classifier with argmax, driving four 7-segment digit codes.
// Latency 2 clock edges image-to-digits, one image per clock, no backpressure.
module bnn_net16_top
   import bnn_net16_pkg::*;
#(
   parameter int THRESH1 = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [IMG_W-1:0][IMG_W-1:0] layer_i,
   output logic [3:0][6:0]             layer_o
);

   localparam logic [4:0] TH1 = 5'(THRESH1);

   img_t            r_img;
   logic [1:0]      r_vld;
   logic [2:0][6:0] r_seg;

   logic [N_HID-1:0][4:0] w_p1;
   logic [N_HID-1:0]      w_hid;
   logic [N_CLS-1:0][4:0] w_score;
   logic [3:0]            w_cls;
   logic [4:0]            w_best;
   logic [3:0]            w_units;
   logic [3:0]            w_tens;

   genvar g;
   generate
      for (g = 0; g < N_HID; g++) begin : g_l1
         bnn_xnor_pop u_pop (
            .i_a   (r_img[g]),
            .i_w   (W1[g]),
            .o_cnt (w_p1[g])
         );
         assign w_hid[g] = (w_p1[g] >= TH1);
      end
      for (g = 0; g < N_CLS; g++) begin : g_l2
         bnn_xnor_pop u_pop (
            .i_a   (w_hid),
            .i_w   (W2[g]),
            .o_cnt (w_score[g])
         );
      end
   endgenerate

   // Strict compare while scanning upward keeps the lowest class on ties.
   always_comb begin
      w_cls  = 4'd0;
      w_best = w_score[0];
      for (int k = 1; k < N_CLS; k++) begin
         if (w_score[k] > w_best) begin
            w_cls  = 4'(k);
            w_best = w_score[k];
         end
      end
   end

   assign w_units = (w_best >= 5'd10) ? 4'(w_best - 5'd10) : w_best[3:0];
   assign w_tens  = (w_best >= 5'd10) ? 4'd1 : 4'd0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_img <= '0;
         r_vld <= 2'b00;
         r_seg <= '0;
      end else begin
         r_img <= layer_i;
         r_vld <= {r_vld[0], 1'b1};
         r_seg <= {seg_of(w_tens), seg_of(w_units), seg_of(w_cls)};
      end
   end

   assign layer_o = {(r_vld[1] ? SEG_DASH : 7'h00), r_seg};

endmodule

// File: tb/tb_bnn_net16_top.sv
// Directed and ROM-replay bench for bnn_net16_top; expectations from hand-worked constants
// and an independent behavioural model of the classifier.
module tb_bnn_net16_top;

   logic                   clk_i = 1'b0;
   logic                   rst_ni;
   logic [15:0][15:0]      layer_i;
   logic [3:0][6:0]        layer_o;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [6:0] SEGT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   localparam logic [27:0] EXP_ONES  = {7'h40, 7'h06, 7'h7D, 7'h3F};
   localparam logic [27:0] EXP_ZERO  = {7'h40, 7'h3F, 7'h6F, 7'h6F};
   localparam logic [27:0] EXP_HALF  = {7'h40, 7'h06, 7'h7D, 7'h7F};
   localparam logic [27:0] EXP_QUART = {7'h40, 7'h06, 7'h4F, 7'h6F};
   localparam logic [27:0] EXP_UPPER = {7'h40, 7'h3F, 7'h7F, 7'h3F};

   bnn_net16_top #(.THRESH1(8)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .layer_i (layer_i),
      .layer_o (layer_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [27:0] model(input logic [15:0][15:0] img);
      logic [15:0] hid;
      logic [15:0] w;
      int cnt, sc, best, cls;
      for (int h = 0; h < 16; h++) begin
         cnt = 0;
         for (int c = 0; c < 16; c++) cnt += int'(img[h][c]);
         hid[h] = (cnt >= 8);
      end
      best = -1;
      cls  = 0;
      for (int k = 0; k < 10; k++) begin
         w  = 16'hFFFF >> k;
         sc = 0;
         for (int b = 0; b < 16; b++) if (hid[b] == w[b]) sc++;
         if (sc > best) begin
            best = sc;
            cls  = k;
         end
      end
      return {7'h40, SEGT[best / 10], SEGT[best % 10], SEGT[cls]};
   endfunction

   // Row r of ROM image i carries a pseudo-random number of ones, rotated into place.
   function automatic logic [15:0][15:0] rom_img(input int i);
      logic [15:0][15:0] img;
      logic [31:0] t;
      logic [15:0] v;
      int n, s;
      for (int r = 0; r < 16; r++) begin
         n = (i * 5 + r * r * 3 + i * r + (i >> 3) * 7) % 17;
         s = (i + r) % 16;
         t = 32'h0000FFFF >> (16 - n);
         v = t[15:0];
         img[r] = (v << s) | (v >> (16 - s));
      end
      return img;
   endfunction

   initial begin
      logic [15:0][15:0] im_ones, im_zero, im_half, im_eight, im_seven, im_chk, im_quart, im_upper;
      logic [15:0][15:0] seq [8];
      logic [27:0]       sexp [8];

      for (int r = 0; r < 16; r++) begin
         im_ones[r]  = 16'hFFFF;
         im_zero[r]  = 16'h0000;
         im_half[r]  = (r < 8) ? 16'hFFFF : 16'h0000;
         im_eight[r] = r[0] ? 16'h0F0F : 16'hAAAA;
         im_seven[r] = r[0] ? 16'hFE00 : 16'h007F;
         im_chk[r]   = r[0] ? 16'h5555 : 16'hAAAA;
         im_quart[r] = (r < 4) ? 16'hFFFF : 16'h0000;
         im_upper[r] = (r >= 8) ? 16'hFFFF : 16'h0000;
      end

      rst_ni  = 1'b0;
      layer_i = im_ones;
      repeat (3) @(negedge clk_i);
      check("reset_hold", layer_o, 28'h0);

      rst_ni = 1'b1;
      @(negedge clk_i);
      check("valid_after_1_edge", {21'd0, layer_o[3]}, 28'h0);
      @(negedge clk_i);
      check("all_ones", layer_o, EXP_ONES);

      layer_i = im_zero;   repeat (2) @(negedge clk_i); check("all_zero", layer_o, EXP_ZERO);
      layer_i = im_half;   repeat (2) @(negedge clk_i); check("half_rows", layer_o, EXP_HALF);
      layer_i = im_eight;  repeat (2) @(negedge clk_i); check("thresh_8", layer_o, EXP_ONES);
      layer_i = im_seven;  repeat (2) @(negedge clk_i); check("thresh_7", layer_o, EXP_ZERO);
      layer_i = im_quart;  repeat (2) @(negedge clk_i); check("rows_0_3", layer_o, EXP_QUART);
      layer_i = im_upper;  repeat (2) @(negedge clk_i); check("rows_8_15", layer_o, EXP_UPPER);

      seq  = '{im_ones, im_zero, im_chk, im_half, im_seven, im_quart, im_upper, im_ones};
      sexp = '{EXP_ONES, EXP_ZERO, EXP_ONES, EXP_HALF, EXP_ZERO, EXP_QUART, EXP_UPPER, EXP_ONES};
      for (int j = 0; j < 10; j++) begin
         @(negedge clk_i);
         if (j >= 2) check($sformatf("b2b_%0d", j - 2), layer_o, sexp[j - 2]);
         if (j < 8) layer_i = seq[j];
      end

      // Reset asserted between edges must blank the display without a clock.
      #2 rst_ni = 1'b0;
      #1 check("reset_async", layer_o, 28'h0);
      @(negedge clk_i);
      check("reset_mid_hold", layer_o, 28'h0);
      layer_i = im_half;
      rst_ni  = 1'b1;
      @(negedge clk_i);
      check("valid_after_rerelease", {21'd0, layer_o[3]}, 28'h0);
      @(negedge clk_i);
      check("first_after_rerelease", layer_o, EXP_HALF);

      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         layer_i = rom_img(i);
         repeat (3) @(negedge clk_i);
         check($sformatf("rom_%0d", i), layer_o, model(rom_img(i)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bnn_net16_top.md
Name: bnn_net16_top

Overview:
- Registered binary neural network classifier for a 16x16 binary image; produces four 7-segment digit codes (class, score, valid mark).
- Sits between an image source (a ROM or sensor block driving a packed 16x16 bit array) and a 4-digit 7-segment display driver.
- Two layers of XNOR-popcount neurons plus argmax; input and output are registered.

Parameters:
- THRESH1, 8, layer-1 activation threshold; hidden bit = 1 when popcount >= THRESH1 (range 0..16).

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_ni  input  1  asynchronous active-low reset.
- layer_i  input  [15:0][15:0]  image; layer_i[r] is row r, layer_i[r][c] is pixel c.
- layer_o  output  [3:0][6:0]  7-seg codes, bit order {g,f,e,d,c,b,a}, active-high; [0] class, [1] score units, [2] score tens, [3] valid mark.

Behaviour:
- Stage 0: image register img_q <= layer_i every clock.
- Layer 1 is combinational from img_q. For hidden neuron h (0..15): p1 = popcount(~(img_q[h] ^ W1[h])); hid[h] = (p1 >= THRESH1). Default W1[h] = 16'hFFFF, so p1 = number of ones in row h.
- Layer 2 is combinational. For class k (0..9): score[k] = popcount(~(hid ^ W2[k])), 5-bit, range 0..16. Default W2[k] = 16'hFFFF >> k (logical shift).
- Argmax: cls = k with maximum score; ties resolve to the lowest k. best = score[cls].
- Stage 1: output register. layer_o[0] = seg(cls); layer_o[1] = seg(best % 10); layer_o[2] = seg(best / 10); layer_o[3] = 7'h40 ('-') when valid, else 7'h00.
- Latency: an image present at rising edge N appears on layer_o after rising edge N+1, i.e. 2 clock edges input-to-output. Throughput is one image per clock. There is no handshake.
- Valid: a 2-bit shift register of 1s cleared by reset. layer_o[3] shows '-' from the second edge after reset release onward.
- Reset (asynchronous, at any time including mid-stream): img_q = 0, valid pipeline = 0, layer_o = all 7'h00 (blank). The first output after reset reflects whatever image was sampled after reset release.
- Segment table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Score width: 5 bits unsigned; 16 is the maximum, so the tens digit is only ever 0 or 1.
- No X propagation: every combinational path is fully assigned.

Decomposition:
- Package bnn_net16_pkg holds:
  - IMG_W = 16, N_HID = 16, N_CLS = 10;
  - typedef img_t [15:0][15:0];
  - W1 and W2 constant arrays;
  - SEG_LUT[10] constant and SEG_DASH.
- One sub-module bnn_xnor_pop (16-bit XNOR plus popcount, 5-bit result), instantiated 26 times via generate.
- The stimulus ROM "data" (output input_o [99:0][15:0][15:0]) is a bench-side constant image store, not part of this RTL.

Test Plan:
- Reset held low with any image -> layer_o = 0 (all four digits blank). Assert rst_ni low mid-stream -> layer_o goes to 0 immediately, without waiting for a clock edge.
- All-ones image, 2 edges after reset release -> hid = FFFF, class 0, score 16; layer_o = {40,06,7D,3F} ([3] down to [0]).
- All-zero image -> hid = 0000, score[k] = k, class 9, score 9; layer_o = {40,3F,6F,6F}.
- Rows 0..7 all ones, rows 8..15 zero -> hid = 00FF, class 8 score 16 (class 9 scores 15); layer_o = {40,06,7D,7F}.
- Threshold boundary: every row has exactly 8 ones -> same output as all-ones. Every row has exactly 7 ones -> same output as all-zero.
- Back-to-back images changing every clock (all-ones, all-zero, alternating) -> outputs follow with exactly 2-edge latency and no skipped or duplicated results. Also replay 100 ROM images spaced far apart and compare against a reference model.
